// File: rtl/shift_sequencer.sv
// Round-robin front end for the single-step shiftLeft datapath: runs one left shift of 0..2^CNT_W-1 per job.
// Optional SHIFT_EARLY_EXIT_EN: leave SHIFT as soon as the work register is all zero.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic [CNT_W-1:0] amt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic [CNT_W-1:0] amt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] sh_in,
  input  logic [WIDTH-1:0] sh_out,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  // Handshake: reqN is held high until gntN; gntN is a combinational accept seen
  // only in IDLE, and the operands present in that cycle are captured on its edge.

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] amt_sel;
  logic             early_exit;

`ifdef SHIFT_EARLY_EXIT_EN
  assign early_exit = (work_q == '0);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    count_d      = count_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    carry_d      = carry_q;
    result_d     = result_q;
    carry_out_d  = carry_out_q;
    done_id_d    = done_id_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    amt_sel      = amt0;
    case (state_q)
      IDLE: begin
        // last_grant_q==1 means port 1 went last, so port 0 wins a tie
        gnt0    = req0 & (~req1 | last_grant_q);
        gnt1    = req1 & (~req0 | ~last_grant_q);
        amt_sel = gnt1 ? amt1 : amt0;
        if (gnt0 | gnt1) begin
          work_d       = gnt1 ? data1 : data0;
          count_d      = amt_sel;
          id_d         = gnt1;
          last_grant_d = gnt1;
          carry_d      = 1'b0;
          state_d      = (amt_sel == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (early_exit) begin
          carry_d = 1'b0;
          state_d = DONE;
        end else begin
          work_d  = sh_out;
          carry_d = work_q[WIDTH-1];
          count_d = count_q - 1'b1;
          if (count_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        result_d    = work_q;
        carry_out_d = carry_q;
        done_id_d   = id_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      work_q       <= '0;
      count_q      <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      carry_q      <= 1'b0;
      result_q     <= '0;
      carry_out_q  <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      count_q      <= count_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      carry_q      <= carry_d;
      result_q     <= result_d;
      carry_out_q  <= carry_out_d;
      done_id_q    <= done_id_d;
    end
  end

  // In DONE the live job values are shown; afterwards the captured copies hold.
  assign sh_in     = work_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = done ? work_q  : result_q;
  assign carry_out = done ? carry_q : carry_out_q;
  assign done_id   = done ? id_q    : done_id_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, contention/reset sequences, and
// randomized traffic scored against an arithmetic model of shift, arbitration and latency.
module tb_shift_sequencer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int EW    = 32 + 2 + WIDTH;
`ifdef SHIFT_EARLY_EXIT_EN
  localparam int LAT_8000 = 3;
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_8000 = 16;
  localparam int LAT_ZERO = 6;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic [CNT_W-1:0] amt0 = '0, amt1 = '0;
  logic             gnt0, gnt1, busy, done, done_id, carry_out;
  logic [WIDTH-1:0] sh_in, sh_out, result;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .amt0(amt0),
    .req1(req1), .data1(data1), .amt1(amt1),
    .gnt0(gnt0), .gnt1(gnt1),
    .sh_in(sh_in), .sh_out(sh_out),
    .busy(busy), .done(done), .done_id(done_id),
    .result(result), .carry_out(carry_out)
  );

  // shiftLeft datapath
  assign sh_out = sh_in << 1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] m_result(input logic [WIDTH-1:0] d, input int amt);
    logic [WIDTH-1:0] r;
    r = d << amt;
    return r;
  endfunction

  function automatic logic m_carry(input logic [WIDTH-1:0] d, input int amt);
    if (amt == 0) return 1'b0;
    return d[WIDTH-amt];
  endfunction

  function automatic int m_lat(input logic [WIDTH-1:0] d, input int amt);
`ifdef SHIFT_EARLY_EXIT_EN
    int z;
    int ctz;
`endif
    if (amt == 0) return 1;
`ifdef SHIFT_EARLY_EXIT_EN
    if (d == '0) z = 0;
    else begin
      ctz = 0;
      while (d[ctz] == 1'b0) ctz++;
      z = WIDTH - ctz;
    end
    if (z < amt) return z + 2;
`endif
    return amt + 1;
  endfunction

  typedef struct {
    bit               port;
    logic [WIDTH-1:0] data;
    int               amt;
    logic [WIDTH-1:0] res;
    bit               carry;
    int               lat;
  } vec_t;

  vec_t vecs[8];
  logic [EW-1:0] exp_q[$];

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scramble_idle();
    req0 = 1'b0; req1 = 1'b0;
    data0 = WIDTH'($urandom); amt0 = CNT_W'($urandom);
    data1 = WIDTH'($urandom); amt1 = CNT_W'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    int g;
    @(negedge clk);
    scramble_idle();
    if (v.port) begin req1 = 1'b1; data1 = v.data; amt1 = CNT_W'(v.amt); end
    else        begin req0 = 1'b1; data0 = v.data; amt0 = CNT_W'(v.amt); end
    #1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (v.port ? gnt1 : gnt0) begin got = 1; break; end
      @(negedge clk); #1;
    end
    check_eq("vec_grant", got, 1);
    g = cyc;
    @(negedge clk);
    scramble_idle();
    #1;
    check_eq("vec_busy", busy, 1);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin got = 1; break; end
      @(negedge clk); #1;
    end
    check_eq("vec_done_seen", got, 1);
    check_eq("vec_latency", cyc - g, v.lat);
    check_eq("vec_result", result, v.res);
    check_eq("vec_carry", carry_out, v.carry);
    check_eq("vec_done_id", done_id, v.port);
    @(negedge clk); #1;
    check_eq("vec_done_pulse", done, 0);
    check_eq("vec_result_hold", result, v.res);
    check_eq("vec_carry_hold", carry_out, v.carry);
  endtask

  int               gc[4], gi[4], dc[4], di[4];
  logic [WIDTH-1:0] dr[4];
  logic             dcar[4];
  int               ng, nd;
  bit               both_seen, g0, g1, got;
  bit               pend[2];
  logic [WIDTH-1:0] pd[2];
  int               pa[2];
  int               last_g, w, exp_w;
  bit               active;
  logic [EW-1:0]    e;

  initial begin
    vecs[0] = '{1'b0, 16'h0021, 1,  16'h0042, 1'b0, 2};
    vecs[1] = '{1'b1, 16'h7676, 4,  16'h6760, 1'b1, 5};
    vecs[2] = '{1'b0, 16'h1234, 0,  16'h1234, 1'b0, 1};
    vecs[3] = '{1'b0, 16'h8000, 15, 16'h0000, 1'b0, LAT_8000};
    vecs[4] = '{1'b1, 16'hFFFF, 15, 16'h8000, 1'b1, 16};
    vecs[5] = '{1'b1, 16'h0000, 5,  16'h0000, 1'b0, LAT_ZERO};
    vecs[6] = '{1'b1, 16'h8001, 1,  16'h0002, 1'b1, 2};
    vecs[7] = '{1'b0, 16'h0001, 15, 16'h8000, 1'b0, 16};

    // reset state
    apply_reset();
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_carry", carry_out, 0);
    check_eq("rst_done_id", done_id, 0);
    check_eq("rst_sh_in", sh_in, 0);
    check_eq("rst_gnt", {gnt1, gnt0}, 0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // continuous contention from reset: alternation starting with port 0
    apply_reset();
    @(negedge clk);
    req0 = 1'b1; data0 = 16'h0003; amt0 = 2;
    req1 = 1'b1; data1 = 16'h4001; amt1 = 2;
    #1;
    ng = 0; nd = 0; both_seen = 0;
    for (int i = 0; i < 18; i++) begin
      if (gnt0 && gnt1) both_seen = 1;
      if ((gnt0 || gnt1) && ng < 4) begin gc[ng] = cyc; gi[ng] = int'(gnt1); ng++; end
      if (done && nd < 4) begin
        dc[nd] = cyc; di[nd] = int'(done_id); dr[nd] = result; dcar[nd] = carry_out; nd++;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    check_eq("cont_exclusive", both_seen, 0);
    check_eq("cont_grants", ng, 4);
    check_eq("cont_dones", nd, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("cont_grant_order", gi[k], k % 2);
      check_eq("cont_done_order", di[k], k % 2);
      check_eq("cont_latency", dc[k] - gc[k], 3);
    end
    for (int k = 0; k < 3; k++) check_eq("cont_regrant_gap", gc[k+1] - dc[k], 1);
    check_eq("cont_res0", dr[0], 16'h000C);
    check_eq("cont_car0", dcar[0], 0);
    check_eq("cont_res1", dr[1], 16'h0004);
    check_eq("cont_car1", dcar[1], 1);

    // reset in the second SHIFT cycle drops the job
    apply_reset();
    @(negedge clk);
    req0 = 1'b1; data0 = 16'h7676; amt0 = 4;
    #1;
    check_eq("rmid_grant", gnt0, 1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    check_eq("rmid_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rmid_busy_clr", busy, 0);
    check_eq("rmid_done_clr", done, 0);
    check_eq("rmid_result_clr", result, 0);
    check_eq("rmid_carry_clr", carry_out, 0);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      #1;
      if (done) got = 1;
    end
    check_eq("rmid_no_done", got, 0);
    @(negedge clk);
    req1 = 1'b1; data1 = 16'h00F0; amt1 = 3;
    #1;
    check_eq("rmid_gnt1", gnt1, 1);
    check_eq("rmid_gnt0", gnt0, 0);
    @(negedge clk);
    req1 = 1'b0;
    #1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1; break; end
      @(negedge clk); #1;
    end
    check_eq("rmid_done_seen", got, 1);
    check_eq("rmid_result", result, 16'h0780);
    check_eq("rmid_carry", carry_out, 0);
    check_eq("rmid_done_id", done_id, 1);

    // randomized traffic
    apply_reset();
    last_g = 1; active = 0; pend[0] = 0; pend[1] = 0;
    exp_q.delete();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && c < 600 && $urandom_range(0, 3) == 0) begin
          pend[p] = 1;
          pa[p]   = $urandom_range(0, 15);
          case ($urandom_range(0, 4))
            0:       pd[p] = '0;
            1:       pd[p] = 16'h8000;
            2:       pd[p] = WIDTH'(1 << $urandom_range(0, 15));
            default: pd[p] = WIDTH'($urandom);
          endcase
        end
      end
      req0  = pend[0];
      data0 = pend[0] ? pd[0] : WIDTH'($urandom);
      amt0  = pend[0] ? CNT_W'(pa[0]) : CNT_W'($urandom);
      req1  = pend[1];
      data1 = pend[1] ? pd[1] : WIDTH'($urandom);
      amt1  = pend[1] ? CNT_W'(pa[1]) : CNT_W'($urandom);
      #1;
      g0 = gnt0; g1 = gnt1;
      if (g0 || g1) begin
        w     = g1 ? 1 : 0;
        exp_w = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
        check_eq("rnd_exclusive", g0 && g1, 0);
        check_eq("rnd_winner", w, exp_w);
        check_eq("rnd_idle_grant", active, 0);
        exp_q.push_back({32'(cyc + m_lat(pd[w], pa[w])), w[0],
                         m_carry(pd[w], pa[w]), m_result(pd[w], pa[w])});
        last_g  = w;
        pend[w] = 0;
        active  = 1;
      end
      if (done) begin
        check_eq("rnd_done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rnd_done_cycle", cyc, e[EW-1 -: 32]);
          check_eq("rnd_done_id", done_id, e[WIDTH+1]);
          check_eq("rnd_carry", carry_out, e[WIDTH]);
          check_eq("rnd_result", result, e[WIDTH-1:0]);
        end
        active = 0;
      end
    end
    check_eq("rnd_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
